// File: rtl/input_request_controller.sv
// Input-instruction responder: stalls the core until the operator confirms the switches,
// then captures the switch bank and releases the CPU for exactly one clock.
module input_request_controller #(
   parameter int SW_WIDTH        = 16,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                clock,
   input  logic                n_reset,
   input  logic                in_req,
   input  logic                confirm_btn,
   input  logic [SW_WIDTH-1:0] switches,
   output logic [SW_WIDTH-1:0] in_data,
   output logic                in_valid,
   output logic                stall,
   output logic                waiting
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RELEASE,
      WAIT_PRESS,
      CAPTURE,
      DONE
   } state_t;

   state_t state, state_next;

   logic                btn_meta, btn_sync;
   logic [SW_WIDTH-1:0] sw_meta, sw_sync;
   logic [CNT_W-1:0]    db_cnt;
   logic                btn_db, btn_db_d;
   logic                btn_rise;

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
         sw_meta  <= '0;
         sw_sync  <= '0;
      end else begin
         btn_meta <= confirm_btn;
         btn_sync <= btn_meta;
         sw_meta  <= switches;
         sw_sync  <= sw_meta;
      end
   end

   // The debounced level flips only after the synced button has differed
   // from it for DEBOUNCE_CYCLES consecutive clocks.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         db_cnt   <= '0;
         btn_db   <= 1'b0;
         btn_db_d <= 1'b0;
      end else begin
         btn_db_d <= btn_db;
         if (btn_sync == btn_db) begin
            db_cnt <= '0;
         end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_db <= btn_sync;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + CNT_W'(1);
         end
      end
   end

   assign btn_rise = btn_db & ~btn_db_d;

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_req) state_next = btn_db ? WAIT_RELEASE : WAIT_PRESS;
         end
         WAIT_RELEASE: begin
            if (!in_req)      state_next = IDLE;
            else if (!btn_db) state_next = WAIT_PRESS;
         end
         WAIT_PRESS: begin
            if (!in_req)       state_next = IDLE;
            else if (btn_rise) state_next = CAPTURE;
         end
         CAPTURE: state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state itself.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state    <= IDLE;
         in_data  <= '0;
         in_valid <= 1'b0;
         waiting  <= 1'b0;
      end else begin
         state    <= state_next;
         in_valid <= (state_next == CAPTURE);
         waiting  <= (state_next == WAIT_RELEASE) || (state_next == WAIT_PRESS);
         if (state_next == CAPTURE) in_data <= sw_sync;
      end
   end

   assign stall = in_req && (state != DONE);

endmodule

// File: doc/input_request_controller.md
Name: input_request_controller

Overview:
- Responder side of the CPU's switch-input path. When the control unit executes an input instruction, this block freezes the PC and waits for the operator to set the switches and press a confirm button.
- It then latches the switch value and releases the CPU for exactly one clock, so the value is consumed once.
- Sits between the board switches/button and the core: its stall output ORs into the program counter hlt input, and in_data feeds the In Signal MUX.

Parameters:
- SW_WIDTH, 16, width of switch bus and captured data.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced button changes state. Must be ≥2; boards use 50000.

Ports:
- clock  input  1  system clock.
- n_reset  input  1  asynchronous active-low reset.
- in_req  input  1  level from control unit: current instruction is an input instruction.
- confirm_btn  input  1  raw, asynchronous, active-high push button.
- switches  input  SW_WIDTH  raw, asynchronous switch bank.
- in_data  output  SW_WIDTH  last captured switch value (registered).
- in_valid  output  1  one-cycle pulse in the capture cycle (registered).
- stall  output  1  hold PC/state; combinational, see below.
- waiting  output  1  prompt LED: high in WAIT_RELEASE and WAIT_PRESS (registered state decode).

Behaviour:
- Reset (n_reset low, immediate):
  - state=IDLE; in_data=0; in_valid=0; waiting=0.
  - Sync flops, debounce counter and debounced button cleared to 0.
- Synchronisers:
  - confirm_btn passes through 2 flops.
  - switches pass through 2 flops per bit.
  - Nothing else samples the raw inputs.
- Debouncer:
  - Counter clears whenever the synced button equals the debounced value.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced value takes the synced value and the counter clears.
  - btn_rise is a 1-cycle pulse when the debounced value goes 0→1.
- State machine, one transition per clock:
  - IDLE: if in_req, go to WAIT_RELEASE if the debounced button=1, else WAIT_PRESS.
  - WAIT_RELEASE: if the debounced button=0, go to WAIT_PRESS. Prevents a held button from satisfying a new request.
  - WAIT_PRESS: on btn_rise, go to CAPTURE.
  - CAPTURE: in_data ← synced switches; in_valid=1 this cycle only; go to DONE.
  - DONE: lasts exactly one cycle, then IDLE.
  - Abort: in WAIT_RELEASE or WAIT_PRESS, if in_req=0, go to IDLE. No capture; in_data is unchanged.
- stall = in_req AND (state != DONE). This is combinational so the PC freezes in the same cycle the input instruction appears.
  - The CPU advances on the clock edge ending the DONE cycle.
  - The CPU reads in_data during DONE; in_data is already stable from CAPTURE.
- Back-to-back input instructions:
  - in_req remains high after DONE, so IDLE immediately begins a new request.
  - A fresh release and press is required; one press never yields two captures.
- Latency: a clean press (raw 0→1 held stable) reaches CAPTURE 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the raw edge.
- in_data holds its value indefinitely between captures. The debouncer runs in all states.
- Presses in IDLE are debounced but ignored.

Test Plan:
- Reset: drive n_reset low mid-simulation, asynchronously to the clock. Required: in_data=0x0000, in_valid=0, waiting=0, stall=in_req immediately; state IDLE after release.
- Basic capture (DEBOUNCE_CYCLES=4): set switches=0x00A5, raise in_req, then press cleanly.
  - stall=1 and waiting=1 until DONE.
  - A single in_valid pulse arrives 7 cycles after the raw edge, with in_data=0x00A5.
  - stall=0 for exactly the DONE cycle.
- Bounce: confirm_btn toggles every 2 cycles for 20 cycles, then holds 1, with switches=0x1234.
  - No in_valid during the bouncing.
  - Exactly one in_valid after the stable hold, with in_data=0x1234.
- Held button: hold the button at 1 before in_req rises.
  - State is WAIT_RELEASE and there is no capture while held.
  - Release, then press with switches=0xBEEF: one capture of 0xBEEF.
- Back-to-back: hold in_req high across two requests.
  - First press captures 0x0001; keep the button held. No second capture occurs until release and re-press.
  - Second press captures 0xFFFF. Two in_valid pulses total.
- Abort: in_data=0x0042 from a prior capture. Raise in_req, drop it during WAIT_PRESS, then press.
  - State returns to IDLE and no in_valid occurs.
  - in_data stays 0x0042; stall follows in_req.
